fft_sm_input_loader: RTL and testbench
======================================

# fft_sm_input_loader

Natural-order sample loader for the 256-point FFT state machine. It accepts a streaming sequence of real samples and stores sample k at bit-reversed address bitrev8(k) in a ping-pong buffer. The FFT core then reads input data by index n over the same 10-bit address / 32-bit data port it uses for the fixed initial-sample table. This lets live data replace the constant table without changing the FFT state machine's read logic.

## Interface

Parameters:
- IN_W, 16, width of incoming signed sample
- DATA_W, 32, width of read data; samples are sign-extended to this width
- LOG2N, 8, log2 of frame length (256 points)
- ADDR_W, 10, width of read index port

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- in_valid  in  1  in_data holds a valid sample
- in_ready  out  1  loader can accept a sample this cycle
- in_data  in  IN_W  signed sample, natural time order
- frame_valid  out  1  a complete frame is available to the reader
- frame_done  in  1  one-cycle pulse; reader has finished with the current frame
- rd_addr  in  ADDR_W  read index n, same meaning as the initial-table index
- rd_data  out  DATA_W  registered read data

## Operation

Storage:
- Two banks, each 256 x DATA_W.
- The write side owns one bank (wbank); the read side owns the other (rbank).
- Each bank has a full flag.

Write side:
- A transfer occurs when in_valid && in_ready.
- Each transfer writes sign_extend(in_data) to bank[wbank][bitrev8(wcnt)], then increments wcnt (8-bit, wraps 255->0).
- On the transfer with wcnt==255: set full[wbank] and toggle wbank.
- in_ready = !full[wbank]. While the target bank is still full, input stalls; no samples are dropped or overwritten.

Read side:
- frame_valid = full[rbank].
- rd_data is registered. On each cycle it is sampled as bank[rbank][rd_addr[7:0]] if rd_addr[9:8]==0, else 0. Out-of-range reads return 0, not X.
- Read value at n equals sample bitrev8(n) of the frame. Example: n=128 returns sample 1.
- frame_done while frame_valid=1: clear full[rbank] and toggle rbank.
- frame_done while frame_valid=0: ignored.

Per-bank states and transitions:
- FILLING → FULL on the 256th write.
- FULL → READING when it becomes rbank with full set.
- READING → FILLING on frame_done.
- Writes and reads never target the same bank while it is FULL or READING.

Simultaneous events:
- frame_done and the final write of the other bank in the same cycle: both take effect. Next cycle, rbank has switched, frame_valid=1 for the new bank, and in_ready=1 for the released bank.

Reset (including mid-frame):
- wcnt=0, wbank=0, rbank=0, both full flags cleared.
- Any partially written frame is discarded; bank contents need not be cleared.

## Timing

- Reset values: in_ready=1, frame_valid=0, rd_data=0.
- Read latency is 1 cycle: rd_addr at edge t gives rd_data after edge t+1.
- frame_valid rises on the edge that accepts the 256th sample, and is visible in the following cycle.
- rd_data for address 0 of a frame is valid no earlier than 1 cycle after frame_valid rises.
- in_ready falls in the cycle after the 256th write only if the newly targeted bank is full. Otherwise input continues back-to-back at one sample per cycle with no bubble at the frame boundary.
- frame_done takes effect on its edge. The first read of the next bank may be issued in the cycle after frame_done.
- Sustained throughput: 1 sample/cycle while the reader releases each frame within 256 cycles of frame_valid.

## Test plan

- Basic fill and read:
  - Stimulus: reset, then stream in_data=k for k=0..255, one per cycle.
  - Response: frame_valid=1 in the cycle after the last transfer.
  - Reads with 1-cycle latency: rd_addr=0→0, 128→1, 1→128, 255→255, 3→192.
- Sign extension:
  - Stimulus: sample k=1 = 16'hFFFE, sample k=2 = 16'h7FFF.
  - Response: rd_addr=128→32'hFFFFFFFE; rd_addr=64→32'h00007FFF.
- Backpressure:
  - Stimulus: stream 600 samples with in_valid always 1 and no frame_done.
  - Response: in_ready=0 after the 512th transfer and exactly 512 transfers are accepted.
  - Then pulse frame_done: in_ready returns to 1 the next cycle and frame_valid stays 1 (second frame).
- Simultaneous release and completion:
  - Stimulus: frame_done on the same edge as the 256th write of frame 2 (frame 1 = k, frame 2 = k+1000).
  - Response: next cycle frame_valid=1 and rd_addr=128 returns 1001.
  - Reader bank swap occurs with no lost frame.
- Out-of-range and spurious done:
  - rd_addr=256 or 10'd1023 returns rd_data=0.
  - frame_done with frame_valid=0 changes no state; a subsequent full frame reads correctly.
- Reset mid-fill:
  - Stimulus: assert reset after 100 samples.
  - Response: frame_valid stays 0 until 256 new samples have been accepted; the reads return only post-reset data.

Source files
------------

// File: rtl/fft_sm_input_loader.sv
// ---------------------------------------------------------------------------
// fft_sm_input_loader
//
// Natural-order sample loader feeding the 256-point FFT state machine.
// Incoming real samples are sign-extended and written to a ping-pong buffer
// at the bit-reversed position of their arrival index, so the FFT core can
// read them by index n exactly as it reads the fixed initial-sample table.
//
// Ports:
//   clk          sole clock, all state updates on the rising edge
//   reset        synchronous active-high reset, clears all control state
//   in_valid     in_data holds a valid sample
//   in_ready     loader can accept a sample this cycle
//   in_data      signed sample in natural time order
//   frame_valid  a complete frame is available to the reader
//   frame_done   one-cycle pulse, reader has finished the current frame
//   rd_addr      read index n (upper bits must be zero for a valid read)
//   rd_data      registered read data, zero for out-of-range indices
// ---------------------------------------------------------------------------
module fft_sm_input_loader #(
    parameter int IN_W   = 16,
    parameter int DATA_W = 32,
    parameter int LOG2N  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic              frame_valid,
    input  logic              frame_done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int NPTS = 1 << LOG2N;

    // Reverse the bit order of a frame index.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] res;
        for (int i = 0; i < LOG2N; i++) begin
            res[i] = idx[LOG2N-1-i];
        end
        return res;
    endfunction

    // Sign-extend an incoming sample to the read-data width.
    function automatic logic [DATA_W-1:0] sext(input logic [IN_W-1:0] smp);
        return {{(DATA_W-IN_W){smp[IN_W-1]}}, smp};
    endfunction

    // Both banks share one array; the bank select is the top address bit.
    logic [DATA_W-1:0] mem_r [0:2*NPTS-1];

    logic [LOG2N-1:0]  wcnt_r;
    logic              wbank_r;
    logic              rbank_r;
    logic [1:0]        full_r;
    logic [DATA_W-1:0] rd_data_r;

    logic [LOG2N-1:0]  wcnt_nxt_s;
    logic              wbank_nxt_s;
    logic              rbank_nxt_s;
    logic [1:0]        full_nxt_s;
    logic              wr_fire_s;
    logic              done_fire_s;
    logic              rd_in_range_s;

    assign in_ready      = ~full_r[wbank_r];
    assign frame_valid   = full_r[rbank_r];
    assign rd_data       = rd_data_r;
    assign wr_fire_s     = in_valid & ~full_r[wbank_r];
    assign done_fire_s   = frame_done & full_r[rbank_r];
    assign rd_in_range_s = (rd_addr[ADDR_W-1:LOG2N] == {(ADDR_W-LOG2N){1'b0}});

    // Next-state for the write counter, bank pointers and full flags.
    // A release and a frame completion in the same cycle always touch
    // different banks (one must be full, the other not), so both apply.
    always_comb begin
        wcnt_nxt_s  = wcnt_r;
        wbank_nxt_s = wbank_r;
        rbank_nxt_s = rbank_r;
        full_nxt_s  = full_r;
        if (done_fire_s) begin
            full_nxt_s[rbank_r] = 1'b0;
            rbank_nxt_s         = ~rbank_r;
        end else begin
            rbank_nxt_s = rbank_r;
        end
        if (wr_fire_s) begin
            wcnt_nxt_s = wcnt_r + {{(LOG2N-1){1'b0}}, 1'b1};
            if (wcnt_r == {LOG2N{1'b1}}) begin
                full_nxt_s[wbank_r] = 1'b1;
                wbank_nxt_s         = ~wbank_r;
            end else begin
                wbank_nxt_s = wbank_r;
            end
        end else begin
            wcnt_nxt_s = wcnt_r;
        end
    end

    // Control state register; reset drops any partially written frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_r  <= {LOG2N{1'b0}};
            wbank_r <= 1'b0;
            rbank_r <= 1'b0;
            full_r  <= 2'b00;
        end else begin
            wcnt_r  <= wcnt_nxt_s;
            wbank_r <= wbank_nxt_s;
            rbank_r <= rbank_nxt_s;
            full_r  <= full_nxt_s;
        end
    end

    // Sample storage write port; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_r[{wbank_r, bitrev(wcnt_r)}] <= sext(in_data);
        end
    end

    // Registered read port; indices beyond one frame read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else if (rd_in_range_s) begin
            rd_data_r <= mem_r[{rbank_r, rd_addr[LOG2N-1:0]}];
        end else begin
            rd_data_r <= {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_fft_sm_input_loader.sv
// ---------------------------------------------------------------------------
// tb_fft_sm_input_loader
//
// Directed bench for fft_sm_input_loader. Inputs change on the falling edge
// and outputs are observed on the falling edge, half a cycle after the
// rising edge that produced them.
// ---------------------------------------------------------------------------
module tb_fft_sm_input_loader;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        frame_valid;
    logic        frame_done;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data;

    int checks = 0;
    int errors = 0;
    int accepted;

    fft_sm_input_loader dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .frame_valid (frame_valid),
        .frame_done  (frame_done),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Stream n samples base..base+n-1, one per cycle.
    task automatic fill(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(base + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Issue a read and compare the registered result one cycle later.
    task automatic rd(input string tag, input int addr, input logic [31:0] exp);
        rd_addr = 10'(addr);
        @(negedge clk);
        chk(tag, rd_data, exp);
    endtask

    task automatic pulse_done();
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = 16'd0;
        frame_done = 1'b0;
        rd_addr    = 10'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);

        // Basic fill and bit-reversed reads
        fill(0, 255);
        chk("fv_before_last", 32'(frame_valid), 32'd0);
        fill(255, 1);
        chk("fv_after_last", 32'(frame_valid), 32'd1);
        chk("ready_after_first", 32'(in_ready), 32'd1);
        rd("rd_0", 0, 32'd0);
        rd("rd_128", 128, 32'd1);
        rd("rd_1", 1, 32'd128);
        rd("rd_255", 255, 32'd255);
        rd("rd_3", 3, 32'd192);

        // Out-of-range reads
        rd("rd_256", 256, 32'd0);
        rd("rd_1023", 1023, 32'd0);
        rd("rd_2_after_oor", 2, 32'd64);

        // Release, then a spurious done with no frame present
        pulse_done();
        chk("fv_after_release", 32'(frame_valid), 32'd0);
        pulse_done();
        chk("fv_after_spurious", 32'(frame_valid), 32'd0);
        chk("ready_after_spurious", 32'(in_ready), 32'd1);

        // Sign extension frame: k=1 -> FFFE, k=2 -> 7FFF, else k
        for (int k = 0; k < 256; k++) begin
            in_valid = 1'b1;
            in_data  = (k == 1) ? 16'hFFFE : (k == 2) ? 16'h7FFF : 16'(k + 500);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("fv_sign_frame", 32'(frame_valid), 32'd1);
        rd("sext_neg", 128, 32'hFFFFFFFE);
        rd("sext_pos", 64, 32'h00007FFF);
        rd("sext_k0", 0, 32'd500);
        pulse_done();
        chk("fv_after_sign_release", 32'(frame_valid), 32'd0);

        // Backpressure: 600 cycles of in_valid, no release
        accepted = 0;
        for (int c = 0; c < 600; c++) begin
            in_valid = 1'b1;
            in_data  = 16'(accepted);
            if (in_ready) accepted++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(accepted), 32'd512);
        chk("bp_ready_low", 32'(in_ready), 32'd0);
        chk("bp_fv", 32'(frame_valid), 32'd1);
        rd("bp_frame_a", 128, 32'd1);
        pulse_done();
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        chk("bp_fv_second", 32'(frame_valid), 32'd1);
        rd("bp_frame_b", 128, 32'd257);
        rd("bp_frame_b0", 0, 32'd256);
        pulse_done();
        chk("bp_fv_drained", 32'(frame_valid), 32'd0);

        // Simultaneous release of frame 1 and completion of frame 2
        fill(0, 256);
        fill(1000, 255);
        in_valid   = 1'b1;
        in_data    = 16'd1255;
        frame_done = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        frame_done = 1'b0;
        chk("sim_fv", 32'(frame_valid), 32'd1);
        chk("sim_ready", 32'(in_ready), 32'd1);
        rd("sim_rd_128", 128, 32'd1001);
        rd("sim_rd_0", 0, 32'd1000);
        rd("sim_rd_255", 255, 32'd1255);
        pulse_done();
        chk("sim_fv_drained", 32'(frame_valid), 32'd0);

        // Reset in the middle of a fill
        fill(2000, 100);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_fv", 32'(frame_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_rd_data", rd_data, 32'd0);
        fill(3000, 255);
        chk("mid_rst_fv_255", 32'(frame_valid), 32'd0);
        fill(3255, 1);
        chk("mid_rst_fv_256", 32'(frame_valid), 32'd1);
        rd("mid_rst_rd_0", 0, 32'd3000);
        rd("mid_rst_rd_128", 128, 32'd3001);
        rd("mid_rst_rd_2", 2, 32'd3064);
        rd("mid_rst_rd_255", 255, 32'd3255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
